// File: rtl/frame_wr_sched_pkg.sv
// frame_wr_sched_pkg: shared SDRAM write-side types, defaults and address layout
package frame_wr_sched_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_FIFO, REQ, DONE} wr_state_e;
  localparam int BURST_LEN_DEF = 512;
  localparam int ROWS_PER_FRAME_DEF = 128;
  localparam int ADDR_W = 24;
  localparam int ROW_W = 13;
  localparam int ROW_LSB = 9;
  // [23]=0, [22]=bank, [21:9]=row, [8:0]=0
  function automatic logic [ADDR_W-1:0] wr_addr(input logic bank, input logic [ROW_W-1:0] row);
    return {1'b0, bank, row, {ROW_LSB{1'b0}}};
  endfunction
endpackage

// File: rtl/frame_wr_sched_if.sv
// frame_wr_sched_if: burst write handshake towards the SDRAM controller
interface frame_wr_sched_if;
  import frame_wr_sched_pkg::*;
  logic              wr_sdram_req;
  logic              wr_sdram_ack;
  logic [ADDR_W-1:0] wr_sdram_add;
  modport master (output wr_sdram_req, output wr_sdram_add, input wr_sdram_ack);
  modport slave  (input wr_sdram_req, input wr_sdram_add, output wr_sdram_ack);
endinterface

// File: rtl/frame_wr_sched.sv
// frame_wr_sched: schedules camera FIFO bursts into double-buffered SDRAM frame banks
module frame_wr_sched
  import frame_wr_sched_pkg::*;
#(
  parameter int BURST_LEN      = BURST_LEN_DEF,
  parameter int ROWS_PER_FRAME = ROWS_PER_FRAME_DEF,
  parameter int FIFO_W         = 11
) (
  input  logic              clk_133M_i,
  input  logic              rst_133i,
  input  logic [FIFO_W-1:0] fifo_used_i,
  input  logic              frame_start_i,
  frame_wr_sched_if.master  wr,
  output logic              frame_done,
  output logic              frame_valid,
  output logic              rd_bank,
  output logic [7:0]        frame_cnt,
  output logic [1:0]        err_flags
);
  wr_state_e state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic bank_q, restart_q, restart_d, frame_valid_q, rd_bank_q;
  logic fifo_ok, ack, restart, last_row;
  logic [7:0] frame_cnt_q;
  logic [1:0] err_q;
  assign fifo_ok  = 32'(fifo_used_i) >= BURST_LEN;
  assign ack      = wr.wr_sdram_ack && state_q == REQ;
  assign restart  = restart_q || frame_start_i;
  assign last_row = row_q == ROW_W'(ROWS_PER_FRAME - 1);
  always_ff @(posedge clk_133M_i) state_q <= rst_133i ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      state_d = frame_start_i ? WAIT_FIFO : IDLE;
      WAIT_FIFO: state_d = (fifo_ok && !frame_start_i) ? REQ : WAIT_FIFO;
      REQ:       state_d = !ack ? REQ : (restart || !last_row) ? WAIT_FIFO : DONE;
      DONE:      state_d = frame_start_i ? WAIT_FIFO : IDLE;
    endcase
  end
  always_comb begin
    wr.wr_sdram_req = state_q == REQ;
    frame_done      = state_q == DONE;
  end
  // a frame_start seen during REQ is held until the burst's ack retires it
  always_comb begin
    row_d = (state_q == DONE || (ack && restart) ||
             (frame_start_i && (state_q == IDLE || state_q == WAIT_FIFO))) ? '0 :
            ack ? row_q + ROW_W'(1) : row_q;
    restart_d = state_q == REQ && !ack && restart;
  end
  always_ff @(posedge clk_133M_i) begin
    if (rst_133i) begin
      row_q         <= '0;
      bank_q        <= 1'b0;
      restart_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      rd_bank_q     <= 1'b0;
      frame_cnt_q   <= '0;
      err_q         <= '0;
    end else begin
      row_q         <= row_d;
      restart_q     <= restart_d;
      bank_q        <= bank_q ^ (state_q == DONE);
      frame_valid_q <= frame_valid_q || state_q == DONE;
      rd_bank_q     <= state_q == DONE ? bank_q : rd_bank_q;
      frame_cnt_q   <= frame_cnt_q + 8'(state_q == DONE);
      err_q         <= err_q | {frame_start_i && (state_q == WAIT_FIFO || state_q == REQ),
                                &fifo_used_i};
    end
  end
  assign wr.wr_sdram_add = wr_addr(bank_q, row_q);
  assign frame_valid     = frame_valid_q;
  assign rd_bank         = rd_bank_q;
  assign frame_cnt       = frame_cnt_q;
  assign err_flags       = err_q;
endmodule

// File: tb/tb_frame_wr_sched.sv
// tb_frame_wr_sched: directed vector table plus full-frame sequences for frame_wr_sched
module tb_frame_wr_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] fifo_used = '0;
  logic        frame_start = 1'b0;
  logic        frame_done, frame_valid, rd_bank;
  logic [7:0]  frame_cnt;
  logic [1:0]  err_flags;
  int n = 0;
  int fails = 0;

  frame_wr_sched_if bus();

  frame_wr_sched dut (
    .clk_133M_i   (clk),
    .rst_133i     (rst),
    .fifo_used_i  (fifo_used),
    .frame_start_i(frame_start),
    .wr           (bus.master),
    .frame_done   (frame_done),
    .frame_valid  (frame_valid),
    .rd_bank      (rd_bank),
    .frame_cnt    (frame_cnt),
    .err_flags    (err_flags)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic        rst, fs, ack;
    logic [10:0] fifo;
    logic        e_req;
    logic [23:0] e_add;
    logic        e_done;
    logic [1:0]  e_err;
  } vec_t;
  vec_t vt[20];

  function automatic logic [23:0] exp_addr(input logic bank, input int row);
    return (24'(bank) << 22) | (24'(row) << 9);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_req();
    int k = 0;
    while (!bus.wr_sdram_req && k < 20) begin
      step();
      k++;
    end
    if (!bus.wr_sdram_req) begin
      n++;
      fails++;
      $display("FAIL req_timeout: got req=0 after %0d cycles, expected req=1", k);
      $display("== %0d vectors applied, %0d miscompares ==", n, fails);
      $fatal(1, "request never arrived");
    end
  endtask

  task automatic run_frame(input int dly, input logic bank, input logic [7:0] cnt,
                           input bit detail, input bit chain);
    for (int r = 0; r < 128; r++) begin
      wait_req();
      if (detail || r == 0 || r == 127) chk("burst_addr", bus.wr_sdram_add, exp_addr(bank, r));
      for (int k = 1; k < dly; k++) step();
      if (detail) begin
        chk("req_held", bus.wr_sdram_req, 1);
        chk("addr_held", bus.wr_sdram_add, exp_addr(bank, r));
      end
      bus.wr_sdram_ack = 1'b1;
      step();
      bus.wr_sdram_ack = 1'b0;
      if (detail && r != 127) begin
        chk("req_drop", bus.wr_sdram_req, 0);
        chk("no_early_done", frame_done, 0);
      end
    end
    chk("frame_done", frame_done, 1);
    chk("req_in_done", bus.wr_sdram_req, 0);
    frame_start = chain;
    step();
    frame_start = 1'b0;
    chk("done_single", frame_done, 0);
    chk("frame_cnt", frame_cnt, cnt);
    chk("rd_bank", rd_bank, bank);
    chk("frame_valid", frame_valid, 1);
  endtask

  initial begin
    bus.wr_sdram_ack = 1'b0;
    //        rst fs ack fifo     req add        done err
    vt[0]  = '{1, 0, 0, 11'd0,    0, 24'h0,     0, 2'b00};
    vt[1]  = '{1, 0, 0, 11'd0,    0, 24'h0,     0, 2'b00};
    vt[2]  = '{0, 0, 0, 11'd600,  0, 24'h0,     0, 2'b00};
    vt[3]  = '{0, 1, 0, 11'd0,    0, 24'h0,     0, 2'b00};
    vt[4]  = '{0, 0, 0, 11'd511,  0, 24'h0,     0, 2'b00};
    vt[5]  = '{0, 0, 0, 11'd511,  0, 24'h0,     0, 2'b00};
    vt[6]  = '{0, 0, 0, 11'd512,  1, 24'h0,     0, 2'b00};
    vt[7]  = '{0, 0, 0, 11'd0,    1, 24'h0,     0, 2'b00};
    vt[8]  = '{0, 0, 1, 11'd0,    0, 24'h200,   0, 2'b00};
    vt[9]  = '{0, 0, 1, 11'd0,    0, 24'h200,   0, 2'b00};
    vt[10] = '{0, 0, 0, 11'd600,  1, 24'h200,   0, 2'b00};
    vt[11] = '{0, 1, 0, 11'd0,    1, 24'h200,   0, 2'b10};
    vt[12] = '{0, 0, 1, 11'd0,    0, 24'h0,     0, 2'b10};
    vt[13] = '{0, 0, 0, 11'd2047, 1, 24'h0,     0, 2'b11};
    vt[14] = '{1, 0, 0, 11'd0,    0, 24'h0,     0, 2'b00};
    vt[15] = '{0, 1, 0, 11'd0,    0, 24'h0,     0, 2'b00};
    vt[16] = '{0, 0, 0, 11'd600,  1, 24'h0,     0, 2'b00};
    vt[17] = '{0, 0, 1, 11'd0,    0, 24'h200,   0, 2'b00};
    vt[18] = '{0, 0, 0, 11'd600,  1, 24'h200,   0, 2'b00};
    vt[19] = '{0, 1, 1, 11'd0,    0, 24'h0,     0, 2'b10};
    #2;
    for (int i = 0; i < 20; i++) begin
      rst = vt[i].rst;
      frame_start = vt[i].fs;
      bus.wr_sdram_ack = vt[i].ack;
      fifo_used = vt[i].fifo;
      step();
      chk($sformatf("v%0d_req", i), bus.wr_sdram_req, vt[i].e_req);
      chk($sformatf("v%0d_add", i), bus.wr_sdram_add, vt[i].e_add);
      chk($sformatf("v%0d_done", i), frame_done, vt[i].e_done);
      chk($sformatf("v%0d_err", i), err_flags, vt[i].e_err);
    end
    frame_start = 1'b0;
    bus.wr_sdram_ack = 1'b0;
    fifo_used = 11'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_valid", frame_valid, 0);
    chk("rst_rd_bank", rd_bank, 0);
    chk("rst_err", err_flags, 0);
    // two detailed frames, the second chained from the first's DONE
    fifo_used = 11'd600;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    run_frame(10, 1'b0, 8'd1, 1'b1, 1'b1);
    run_frame(10, 1'b1, 8'd2, 1'b1, 1'b0);
    step();
    step();
    chk("idle_no_req", bus.wr_sdram_req, 0);
    chk("idle_valid", frame_valid, 1);
    chk("chain_no_err", err_flags, 0);
    // restart at row 40 while the request is pending
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int r = 0; r < 40; r++) begin
      wait_req();
      bus.wr_sdram_ack = 1'b1;
      step();
      bus.wr_sdram_ack = 1'b0;
    end
    wait_req();
    chk("row40_addr", bus.wr_sdram_add, exp_addr(1'b0, 40));
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("restart_err", err_flags, 2'b10);
    chk("restart_req_held", bus.wr_sdram_req, 1);
    chk("restart_addr_held", bus.wr_sdram_add, exp_addr(1'b0, 40));
    bus.wr_sdram_ack = 1'b1;
    step();
    bus.wr_sdram_ack = 1'b0;
    chk("restart_req_drop", bus.wr_sdram_req, 0);
    chk("restart_no_done", frame_done, 0);
    wait_req();
    chk("restart_addr", bus.wr_sdram_add, exp_addr(1'b0, 0));
    chk("restart_cnt", frame_cnt, 2);
    // reset in REQ drops the request immediately
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_req_drop", bus.wr_sdram_req, 0);
    chk("rst_err_clr", err_flags, 0);
    chk("rst_cnt_clr", frame_cnt, 0);
    chk("rst_valid_clr", frame_valid, 0);
    // 256 fast frames: counter wraps, read bank alternates
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int f = 0; f < 256; f++) run_frame(1, f[0], 8'(f + 1), 1'b0, 1'b1);
    chk("wrap_cnt", frame_cnt, 0);
    chk("wrap_err", err_flags, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
